// File: rtl/hazard_scoreboard_pkg.sv
// Shared sizing and types for the register hazard scoreboard.
// Optional forwarding support is selected with the HAZARD_FORWARDING_EN macro.
package hazard_pkg;
    localparam int REG_AW   = 4;
    localparam int LAT_W    = 3;
    localparam int CNT_W    = 16;
    localparam int NUM_REGS = 2 ** REG_AW;

    typedef logic [REG_AW-1:0] reg_id_t;
    typedef logic [LAT_W-1:0]  lat_t;
endpackage

// File: rtl/hazard_scoreboard_sb_entry.sv
// One scoreboard slot: pending bit for an in-flight write plus a countdown
// to the cycle in which the result reaches the forward path.
module sb_entry #(
    parameter int LAT_W = hazard_pkg::LAT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             set,
    input  logic [LAT_W-1:0] set_lat,
    input  logic             clr,
    output logic             pending,
    output logic             ready
);
    logic [LAT_W-1:0] count;

    // Pending bit: a new issue outranks a same-cycle writeback clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            pending <= 1'b0;
        else if (set)
            pending <= 1'b1;
        else if (clr)
            pending <= 1'b0;
    end

    // Countdown loads the op latency on issue, otherwise drains to zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count <= '0;
        else if (set)
            count <= set_lat;
        else if (count != '0)
            count <= count - 1'b1;
    end

    assign ready = (count == '0);
endmodule

// File: rtl/hazard_scoreboard.sv
// ID-stage register scoreboard: RAW/WAW stall detection over all in-flight
// writes, stall-cycle counter and sticky bad-writeback flag.
// Define HAZARD_FORWARDING_EN to release stalls once results are forwardable.
module hazard_scoreboard #(
    parameter int REG_AW = hazard_pkg::REG_AW,
    parameter int LAT_W  = hazard_pkg::LAT_W,
    parameter int CNT_W  = hazard_pkg::CNT_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 id_valid,
    input  logic [REG_AW-1:0]    id_src1,
    input  logic [REG_AW-1:0]    id_src2,
    input  logic                 id_two_src,
    input  logic [REG_AW-1:0]    id_dest,
    input  logic                 id_wb_en,
    input  logic [LAT_W-1:0]     id_lat,
    input  logic                 flush,
    input  logic                 wb_valid,
    input  logic [REG_AW-1:0]    wb_dest,
    output logic                 hazard,
    output logic                 fwd1_en,
    output logic                 fwd2_en,
    output logic [2**REG_AW-1:0] pending,
    output logic [CNT_W-1:0]     stall_cnt,
    output logic                 sb_err
);
    localparam int NREG = 2 ** REG_AW;

    logic [NREG-1:0] ready_vec;
    logic            wb_hit1, wb_hit2, wb_hit_d;
    logic            busy1, busy2, busy_d;
    logic            issue, err_set;

    // Per-register slots; set/clear are decoded from the issue and writeback ids.
    for (genvar i = 0; i < NREG; i++) begin : g_entry
        sb_entry #(.LAT_W(LAT_W)) u_entry (
            .clk     (clk),
            .rst     (rst),
            .set     (issue && (id_dest == REG_AW'(i))),
            .set_lat (id_lat),
            .clr     (wb_valid && (wb_dest == REG_AW'(i))),
            .pending (pending[i]),
            .ready   (ready_vec[i])
        );
    end

    // Busy/forward decisions; a same-cycle writeback hides the dependency.
    always_comb begin
        wb_hit1 = wb_valid && (wb_dest == id_src1);
        wb_hit2 = wb_valid && (wb_dest == id_src2);
        wb_hit_d = wb_valid && (wb_dest == id_dest);
`ifdef HAZARD_FORWARDING_EN
        busy1   = pending[id_src1] && !ready_vec[id_src1] && !wb_hit1;
        busy2   = pending[id_src2] && !ready_vec[id_src2] && !wb_hit2;
        busy_d  = pending[id_dest] && !ready_vec[id_dest] && !wb_hit_d;
        fwd1_en = id_valid && pending[id_src1] && ready_vec[id_src1] && !wb_hit1;
        fwd2_en = id_valid && id_two_src && pending[id_src2] && ready_vec[id_src2] && !wb_hit2;
`else
        busy1   = pending[id_src1] && !wb_hit1;
        busy2   = pending[id_src2] && !wb_hit2;
        busy_d  = pending[id_dest] && !wb_hit_d;
        fwd1_en = 1'b0;
        fwd2_en = 1'b0;
`endif
        hazard  = id_valid && !flush &&
                  (busy1 || (id_two_src && busy2) || (id_wb_en && busy_d));
        issue   = id_valid && !flush && !hazard && id_wb_en;
        err_set = wb_valid && !pending[wb_dest] && !(issue && (id_dest == wb_dest));
    end

`ifndef HAZARD_FORWARDING_EN
    // Countdowns only matter when forwarding is built in.
    logic unused_ready;
    assign unused_ready = ^ready_vec;
`endif

    // Saturating stall-cycle counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_cnt <= '0;
        else if (hazard && (stall_cnt != '1))
            stall_cnt <= stall_cnt + 1'b1;
    end

    // Sticky flag for a writeback nobody was waiting for.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            sb_err <= 1'b0;
        else if (err_set)
            sb_err <= 1'b1;
    end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: vector table, directed corner
// sequences and randomized traffic against a cycle-indexed reference model.
module tb_hazard_scoreboard;
    import hazard_pkg::*;

`ifdef HAZARD_FORWARDING_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif
    localparam int NR = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          id_valid, id_two_src, id_wb_en, flush, wb_valid;
    reg_id_t       id_src1, id_src2, id_dest, wb_dest;
    lat_t          id_lat;
    logic          hazard, fwd1_en, fwd2_en, sb_err;
    logic [NR-1:0] pending;
    logic [15:0]   stall_cnt;

    hazard_scoreboard dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
        .id_two_src(id_two_src), .id_dest(id_dest), .id_wb_en(id_wb_en), .id_lat(id_lat),
        .flush(flush), .wb_valid(wb_valid), .wb_dest(wb_dest), .hazard(hazard),
        .fwd1_en(fwd1_en), .fwd2_en(fwd2_en), .pending(pending), .stall_cnt(stall_cnt),
        .sb_err(sb_err)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: a write issued in cycle t becomes forwardable in cycle t+1+lat.
    bit     mpend [NR];
    longint mready[NR];
    longint cyc = 0;
    int     mstall = 0;
    bit     merr = 1'b0;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic bit m_wbhit(int r);
        return wb_valid && (int'(wb_dest) == r);
    endfunction

    function automatic bit m_busy(int r);
        return mpend[r] && !m_wbhit(r) && (!FWD || cyc < mready[r]);
    endfunction

    function automatic bit m_fwd(int r);
        return FWD && mpend[r] && cyc >= mready[r] && !m_wbhit(r);
    endfunction

    function automatic bit m_hazard();
        return id_valid && !flush && (m_busy(int'(id_src1)) ||
               (id_two_src && m_busy(int'(id_src2))) || (id_wb_en && m_busy(int'(id_dest))));
    endfunction

    function automatic logic [NR-1:0] m_pendvec();
        logic [NR-1:0] v = '0;
        for (int r = 0; r < NR; r++) v[r] = mpend[r];
        return v;
    endfunction

    task automatic model_reset();
        for (int r = 0; r < NR; r++) begin
            mpend[r] = 1'b0;
            mready[r] = 0;
        end
        mstall = 0;
        merr = 1'b0;
    endtask

    // Called at the negative edge: compare all outputs, advance the model, move past the edge.
    task automatic step();
        bit hz, iss;
        hz = m_hazard();
        chk("hazard", 32'(hazard), 32'(hz));
        chk("fwd1_en", 32'(fwd1_en), 32'(id_valid && m_fwd(int'(id_src1))));
        chk("fwd2_en", 32'(fwd2_en), 32'(id_valid && id_two_src && m_fwd(int'(id_src2))));
        chk("pending", 32'(pending), 32'(m_pendvec()));
        chk("stall_cnt", 32'(stall_cnt), 32'(mstall));
        chk("sb_err", 32'(sb_err), 32'(merr));
        iss = id_valid && !flush && !hz && id_wb_en;
        if (wb_valid) begin
            if (!mpend[wb_dest] && !(iss && id_dest == wb_dest)) merr = 1'b1;
            mpend[wb_dest] = 1'b0;
        end
        if (iss) begin
            mpend[id_dest] = 1'b1;
            mready[id_dest] = cyc + 1 + longint'(id_lat);
        end
        if (hz && mstall < 65535) mstall++;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic tick();
        @(negedge clk);
        step();
    endtask

    task automatic idle();
        id_valid = 0; id_src1 = '0; id_src2 = '0; id_two_src = 0; id_dest = '0;
        id_wb_en = 0; id_lat = '0; flush = 0; wb_valid = 0; wb_dest = '0;
    endtask

    task automatic set_id(int s1, int s2, bit two, int d, bit we, int lat);
        id_valid = 1; id_src1 = 4'(s1); id_src2 = 4'(s2); id_two_src = two;
        id_dest = 4'(d); id_wb_en = we; id_lat = 3'(lat);
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc++;
    endtask

    typedef struct {
        bit v; int s1; int s2; bit two; int d; bit we; int lat; bit fl; bit wbv; int wbd;
        bit e_hz; logic [15:0] e_pend; bit e_err; int e_stall;
    } vec_t;
    vec_t tbl[11];

    function automatic vec_t mk(bit v, int s1, int s2, bit two, int d, bit we, int lat, bit fl,
                                bit wbv, int wbd, bit e_hz, logic [15:0] e_pend, bit e_err,
                                int e_stall);
        vec_t t;
        t.v = v; t.s1 = s1; t.s2 = s2; t.two = two; t.d = d; t.we = we; t.lat = lat;
        t.fl = fl; t.wbv = wbv; t.wbd = wbd; t.e_hz = e_hz; t.e_pend = e_pend;
        t.e_err = e_err; t.e_stall = e_stall;
        return t;
    endfunction

    initial begin
        //            v  s1 s2 two d we lat fl wbv wbd  hz  pend       err stall
        tbl[0]  = mk(1, 0, 0, 0, 2, 1, 7, 0, 0, 0,    0, 16'h0000, 0, 0); // issue R2
        tbl[1]  = mk(1, 3, 0, 0, 4, 0, 0, 0, 0, 0,    0, 16'h0004, 0, 0); // unrelated src
        tbl[2]  = mk(1, 0, 0, 0, 2, 1, 7, 0, 0, 0,    1, 16'h0004, 0, 0); // WAW on R2
        tbl[3]  = mk(1, 0, 0, 0, 2, 1, 7, 1, 0, 0,    0, 16'h0004, 0, 1); // WAW flushed
        tbl[4]  = mk(1, 2, 0, 0, 0, 0, 0, 0, 1, 2,    0, 16'h0004, 0, 1); // same-cycle wb R2
        tbl[5]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,    0, 16'h0000, 0, 1); // R2 cleared
        tbl[6]  = mk(1, 0, 9, 1, 9, 1, 7, 0, 0, 0,    0, 16'h0000, 0, 1); // issue R9
        tbl[7]  = mk(1, 0, 9, 0, 0, 0, 0, 0, 0, 0,    0, 16'h0200, 0, 1); // src2 ignored
        tbl[8]  = mk(1, 0, 9, 1, 0, 0, 0, 0, 0, 0,    1, 16'h0200, 0, 1); // src2 RAW
        tbl[9]  = mk(1, 0, 0, 0, 9, 1, 7, 0, 1, 9,    0, 16'h0200, 0, 2); // issue+wb R9
        tbl[10] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,    0, 16'h0200, 0, 2); // issue won

        idle();
        rst = 1'b0;
        do_reset();

        // Reset state
        @(negedge clk);
        chk("rst_pending", 32'(pending), 32'h0);
        chk("rst_stall", 32'(stall_cnt), 32'h0);
        chk("rst_err", 32'(sb_err), 32'h0);
        chk("rst_hazard", 32'(hazard), 32'h0);
        step();

        // Vector table
        for (int i = 0; i < 11; i++) begin
            set_id(tbl[i].s1, tbl[i].s2, tbl[i].two, tbl[i].d, tbl[i].we, tbl[i].lat);
            id_valid = tbl[i].v; flush = tbl[i].fl;
            wb_valid = tbl[i].wbv; wb_dest = 4'(tbl[i].wbd);
            @(negedge clk);
            chk($sformatf("tbl%0d_hazard", i), 32'(hazard), 32'(tbl[i].e_hz));
            chk($sformatf("tbl%0d_pending", i), 32'(pending), 32'(tbl[i].e_pend));
            chk($sformatf("tbl%0d_err", i), 32'(sb_err), 32'(tbl[i].e_err));
            chk($sformatf("tbl%0d_stall", i), 32'(stall_cnt), 32'(tbl[i].e_stall));
            step();
        end

        // RAW on a lat=2 result, with and without forwarding
        do_reset();
        set_id(0, 0, 0, 3, 1, 2);
        tick();
        set_id(3, 0, 0, 0, 0, 0);
`ifdef HAZARD_FORWARDING_EN
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("raw_fwd_stall", 32'(hazard), 32'h1);
            step();
        end
        @(negedge clk);
        chk("raw_fwd_release", 32'(hazard), 32'h0);
        chk("raw_fwd1_en", 32'(fwd1_en), 32'h1);
        step();
`else
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("raw_stall", 32'(hazard), 32'h1);
            chk("raw_no_fwd", 32'(fwd1_en), 32'h0);
            step();
        end
`endif
        wb_valid = 1; wb_dest = 4'd3;
        @(negedge clk);
        chk("raw_wb_release", 32'(hazard), 32'h0);
        step();
        idle();
        tick();

        // Asynchronous reset mid-run with R4..R7 pending and ID stalled
        do_reset();
        for (int r = 4; r < 8; r++) begin
            set_id(0, 0, 0, r, 1, 7);
            tick();
        end
        set_id(4, 0, 0, 0, 0, 0);
        tick();
        @(negedge clk);
        chk("pre_rst_pending", 32'(pending), 32'h00F0);
        step();
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_pending", 32'(pending), 32'h0);
        chk("mid_rst_stall", 32'(stall_cnt), 32'h0);
        chk("mid_rst_hazard", 32'(hazard), 32'h0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle();
        cyc++;
        tick();

        // Randomized traffic against the model
        for (int i = 0; i < 2000; i++) begin
            int pl[$];
            id_valid = ($urandom_range(0, 9) < 8);
            id_src1 = 4'($urandom_range(0, 15));
            id_src2 = 4'($urandom_range(0, 15));
            id_two_src = 1'($urandom_range(0, 1));
            id_dest = 4'($urandom_range(0, 15));
            id_wb_en = 1'($urandom_range(0, 1));
            id_lat = 3'($urandom_range(0, 7));
            flush = ($urandom_range(0, 9) == 0);
            for (int r = 0; r < NR; r++) if (mpend[r]) pl.push_back(r);
            wb_valid = 0;
            wb_dest = '0;
            if (pl.size() > 0 && $urandom_range(0, 9) < 4) begin
                wb_valid = 1;
                wb_dest = 4'(pl[$urandom_range(0, pl.size() - 1)]);
            end else if ($urandom_range(0, 49) == 0) begin
                wb_valid = 1;
                wb_dest = 4'($urandom_range(0, 15));
            end
            tick();
        end

        // Long stall run: the stall counter must saturate
        do_reset();
        set_id(1, 0, 0, 1, 1, 7);
        repeat (76000) @(posedge clk);
        #1;
        idle();
        wb_valid = 1; wb_dest = 4'd1;
        for (int r = 0; r < NR; r++) mpend[r] = (r == 1);
        mstall = 65535;
        @(negedge clk);
        chk("sat_stall_cnt", 32'(stall_cnt), 32'hFFFF);
        chk("sat_pending", 32'(pending), 32'h0002);
        step();

        // Writeback to a non-pending register latches sb_err until reset
        idle();
        wb_valid = 1; wb_dest = 4'd9;
        @(negedge clk);
        chk("err_before", 32'(sb_err), 32'h0);
        step();
        idle();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("err_sticky", 32'(sb_err), 32'h1);
            step();
        end
        do_reset();
        @(negedge clk);
        chk("err_cleared", 32'(sb_err), 32'h0);
        chk("stall_cleared", 32'(stall_cnt), 32'h0);
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
